// File: rtl/pmem_responder_if.sv
// Block-wide pmem request/response bundle between the L2 cache (master) and
// the backing store (slave).
interface pmem_responder_if #(
    parameter int BLOCK_BITS = 256
) ();
    logic                  pmem_read;
    logic                  pmem_write;
    logic [15:0]           pmem_address;
    logic [BLOCK_BITS-1:0] pmem_wdata;
    logic [BLOCK_BITS-1:0] pmem_rdata;
    logic                  pmem_resp;
    logic                  protocol_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, protocol_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, protocol_err
    );
endinterface

// File: rtl/pmem_responder.sv
// Block-addressed pmem backing store with fixed per-command latency and a
// one-cycle completion pulse. Define PMEM_PROTOCOL_CHECK_EN for protocol_err checking.
module pmem_responder #(
    parameter int BLOCK_BITS    = 256,
    parameter int DEPTH_LOG2    = 11,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    pmem_responder_if.slave  bus
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [BLOCK_BITS-1:0]   wdata_q, wdata_d;
    logic [BLOCK_BITS-1:0]   rdata_q;
    logic [BLOCK_BITS-1:0]   mem [DEPTH];
    logic                    accept;
    logic                    commit;
    logic                    unused_addr;

    assign accept = (state_q == IDLE) && (bus.pmem_read || bus.pmem_write);
    assign commit = (state_q == BUSY) && (cnt_q == '0);
    assign unused_addr = ^bus.pmem_address;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Write wins when both request lines are high.
                    is_write_d = bus.pmem_write;
                    idx_d      = bus.pmem_address[DEPTH_LOG2+4:5];
                    wdata_d    = bus.pmem_wdata;
                    cnt_d      = bus.pmem_write ? WR_LOAD : RD_LOAD;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            if (commit && !is_write_q) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && is_write_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.pmem_rdata = rdata_q;
    assign bus.pmem_resp  = (state_q == RESP);

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic        rd_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic        err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && bus.pmem_read && bus.pmem_write) begin
            err_d = 1'b1;
        end
        // Any deviation from the latched request while busy, including a dropped request.
        if (state_q == BUSY &&
            (bus.pmem_read != rd_q || bus.pmem_write != wr_q ||
             bus.pmem_address != addr_q ||
             (is_write_q && bus.pmem_wdata != wdata_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept) begin
                rd_q   <= bus.pmem_read;
                wr_q   <= bus.pmem_write;
                addr_q <= bus.pmem_address;
            end
        end
    end

    assign bus.protocol_err = err_q;
`else
    assign bus.protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: a latency-4 / 2048-block instance and a
// small aliasing instance with read latency 1 and write latency 2.
module tb_pmem_responder;
    localparam int BB = 256;
    localparam logic EXP_ERR =
`ifdef PMEM_PROTOCOL_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_responder_if #(.BLOCK_BITS(BB)) bus_a ();
    pmem_responder_if #(.BLOCK_BITS(BB)) bus_b ();

    pmem_responder #(.BLOCK_BITS(BB), .DEPTH_LOG2(11), .READ_LATENCY(4), .WRITE_LATENCY(4))
        dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    pmem_responder #(.BLOCK_BITS(BB), .DEPTH_LOG2(4), .READ_LATENCY(1), .WRITE_LATENCY(2))
        dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    typedef struct {
        int           cyc;
        logic [BB-1:0] rdata;
        string        name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [BB-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [BB-1:0] PAT_P  = {8{32'hC3C3_0F0F}};
    localparam logic [BB-1:0] PAT_D  = {16{16'h1234}};
    localparam logic [BB-1:0] PAT_DB = {8{32'hDEAD_BEEF}};
    localparam logic [BB-1:0] PAT_X  = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [BB-1:0] PAT_Y  = {8{32'h5A5A_F00D}};

    function automatic void check(input string name, input logic [BB-1:0] act,
                                  input logic [BB-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic logic get_resp(input int d);
        return (d == 0) ? bus_a.pmem_resp : bus_b.pmem_resp;
    endfunction

    task automatic set_bus(input int d, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [BB-1:0] wd);
        if (d == 0) begin
            bus_a.pmem_read = rd; bus_a.pmem_write = wr;
            bus_a.pmem_address = addr; bus_a.pmem_wdata = wd;
        end else begin
            bus_b.pmem_read = rd; bus_b.pmem_write = wr;
            bus_b.pmem_address = addr; bus_b.pmem_wdata = wd;
        end
    endtask

    task automatic push_exp(input int d, input int c, input logic [BB-1:0] rd, input string name);
        exp_t e;
        e.cyc = c; e.rdata = rd; e.name = name;
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    task automatic wait_resp(input int d, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (get_resp(d)) seen = 1'b1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no resp, expected resp within 40 cycles", name);
            if (d == 0) q_a.delete(); else q_b.delete();
        end
    endtask

    // One complete access; expectation pushed when the request is driven.
    task automatic access(input int d, input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [BB-1:0] wd, input int lat,
                          input logic [BB-1:0] exp_rdata, input string name);
        @(negedge clk);
        set_bus(d, rd, wr, addr, wd);
        push_exp(d, cyc + 1 + lat, exp_rdata, name);
        wait_resp(d, name);
        set_bus(d, 1'b0, 1'b0, addr, wd);
    endtask

    // Start an access on dut_a and hit reset during the second BUSY cycle.
    task automatic abort_a(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [BB-1:0] wd, input string name);
        @(negedge clk);
        set_bus(0, rd, wr, addr, wd);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_a = 1'b1;
        set_bus(0, 1'b0, 1'b0, addr, wd);
        #1;
        check({name, "_resp"},  BB'(bus_a.pmem_resp), '0);
        check({name, "_rdata"}, bus_a.pmem_rdata, '0);
        check({name, "_perr"},  BB'(bus_a.protocol_err), '0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    // Scoreboard monitor: every resp pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.pmem_resp === 1'b1) begin
            if (q_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL stray_resp_a: got resp at cycle %0d, expected none", cyc);
            end else begin
                e = q_a.pop_front();
                check({e.name, "_cyc"}, BB'(cyc), BB'(e.cyc));
                check({e.name, "_rdata"}, bus_a.pmem_rdata, e.rdata);
            end
        end
        if (bus_b.pmem_resp === 1'b1) begin
            if (q_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL stray_resp_b: got resp at cycle %0d, expected none", cyc);
            end else begin
                e = q_b.pop_front();
                check({e.name, "_cyc"}, BB'(cyc), BB'(e.cyc));
                check({e.name, "_rdata"}, bus_b.pmem_rdata, e.rdata);
            end
        end
    end

    initial begin
        int k;
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_bus(0, 1'b0, 1'b0, 16'h0000, '0);
        set_bus(1, 1'b0, 1'b0, 16'h0000, '0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("init_resp_a",  BB'(bus_a.pmem_resp), '0);
        check("init_rdata_a", bus_a.pmem_rdata, '0);
        check("init_perr_a",  BB'(bus_a.protocol_err), '0);
        check("init_resp_b",  BB'(bus_b.pmem_resp), '0);
        check("init_rdata_b", bus_b.pmem_rdata, '0);

        // dut_a: write/read, same-block offset, upper index bits, no aliasing at depth 2048.
        access(0, 1'b0, 1'b1, 16'h0040, PAT_A5, 4, '0,     "a_wr_0040");
        access(0, 1'b1, 1'b0, 16'h0040, '0,     4, PAT_A5, "a_rd_0040");
        access(0, 1'b1, 1'b0, 16'h005F, '0,     4, PAT_A5, "a_rd_005f");
        access(0, 1'b0, 1'b1, 16'h0840, PAT_P,  4, PAT_A5, "a_wr_0840");
        access(0, 1'b1, 1'b0, 16'h0840, '0,     4, PAT_P,  "a_rd_0840");
        access(0, 1'b1, 1'b0, 16'h0040, '0,     4, PAT_A5, "a_rd_0040b");
        check("perr_clean_a", BB'(bus_a.protocol_err), '0);

        // Simultaneous read+write behaves as a write; rdata untouched.
        access(0, 1'b1, 1'b1, 16'h0100, PAT_D,  4, PAT_A5, "a_rdwr_0100");
        check("perr_both_a", BB'(bus_a.protocol_err), BB'(EXP_ERR));
        access(0, 1'b1, 1'b0, 16'h0100, '0,     4, PAT_D,  "a_rd_0100");
        check("perr_sticky_a", BB'(bus_a.protocol_err), BB'(EXP_ERR));

        // Held read: re-accepted in the IDLE cycle after RESP, one pulse each.
        @(negedge clk);
        set_bus(0, 1'b1, 1'b0, 16'h0100, '0);
        k = cyc + 1;
        push_exp(0, k + 4,  PAT_D, "a_held1");
        push_exp(0, k + 10, PAT_D, "a_held2");
        wait_resp(0, "a_held1");
        @(negedge clk);
        @(negedge clk);
        set_bus(0, 1'b0, 1'b0, 16'h0100, '0);
        wait_resp(0, "a_held2");

        // Reset mid-read and mid-write; the aborted write must not reach the array.
        abort_a(1'b1, 1'b0, 16'h0840, '0,     "a_abort_rd");
        abort_a(1'b0, 1'b1, 16'h0040, PAT_DB, "a_abort_wr");
        access(0, 1'b1, 1'b0, 16'h0040, '0, 4, PAT_A5, "a_rd_after_rst");
        check("perr_after_rst_a", BB'(bus_a.protocol_err), '0);

        // dut_b: 16 blocks so address bit 9 aliases; read latency 1, write latency 2.
        access(1, 1'b0, 1'b1, 16'h0020, PAT_X, 2, '0,    "b_wr_0020");
        access(1, 1'b1, 1'b0, 16'h0220, '0,    1, PAT_X, "b_rd_0220");
        access(1, 1'b0, 1'b1, 16'h0000, PAT_Y, 2, PAT_X, "b_wr_0000");
        access(1, 1'b1, 1'b0, 16'h0200, '0,    1, PAT_Y, "b_rd_0200");
        access(1, 1'b1, 1'b0, 16'h0020, '0,    1, PAT_X, "b_rd_0020");
        check("perr_clean_b", BB'(bus_b.protocol_err), '0);

        repeat (8) @(negedge clk);
        check("q_a_drained", BB'(q_a.size()), '0);
        check("q_b_drained", BB'(q_b.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Physical-memory-side responder for the L2 cache's pmem interface: it services the block-wide read and write requests that the L2 cache issues.
- Holds a block-addressed storage array and applies a programmable access latency per command.
- Acknowledges each request with a one-cycle pmem_resp pulse.
- Used as the main-memory model under the pipelined LC-3b core and as a synthesizable on-chip backing store.

Parameters:
BLOCK_BITS, 256, width of one pmem block (matches lc3b_l2_block)
DEPTH_LOG2, 11, log2 of number of blocks stored (2048 blocks = 64 KB)
READ_LATENCY, 4, cycles from request acceptance to pmem_resp for a read; min 1
WRITE_LATENCY, 4, cycles from request acceptance to pmem_resp for a write; min 1

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
pmem_read  input  1  read request; held high by requester until pmem_resp seen
pmem_write  input  1  write request; held high by requester until pmem_resp seen
pmem_address  input  16  byte address (lc3b_word); block index = pmem_address[DEPTH_LOG2+4:5], low 5 bits ignored
pmem_wdata  input  BLOCK_BITS  write block, sampled at acceptance
pmem_rdata  output  BLOCK_BITS  read block; valid while pmem_resp high
pmem_resp  output  1  one-cycle completion pulse
protocol_err  output  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset (async, any state, including mid-access):
  - state to IDLE; pmem_resp=0, pmem_rdata=0, protocol_err=0, latency counter=0.
  - Storage array is NOT cleared; an aborted write leaves the array unchanged.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If pmem_write=1 or pmem_read=1 at a rising edge, latch command, block index and pmem_wdata; load counter with LATENCY-1; go to BUSY.
  - If both are high, the command is a write (write priority).
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==0: a write stores the latched wdata to the latched index; a read loads pmem_rdata from the latched index. Then go to RESP.
- RESP:
  - pmem_resp=1 for exactly this one cycle; next edge returns to IDLE.
  - A request still high in the IDLE cycle that follows is treated as new.
- Latency: a request accepted at edge k gives pmem_resp high in the cycle following edge k+LATENCY. With LATENCY=1, resp is high in the cycle after the edge following acceptance.
- Inputs changing during BUSY/RESP are ignored; the latched values are used.
- pmem_rdata holds its last read value outside RESP; writes never change it.
- Read of the block written by the immediately preceding write returns the new data (the write commits before RESP).
- Address bits above DEPTH_LOG2+4 are ignored, so the address space aliases modulo depth.
- Back-to-back throughput: one access per LATENCY+2 cycles (accept edge, LATENCY edges, RESP cycle).

Optional Feature:
- Macro PMEM_PROTOCOL_CHECK_EN.
- Defined: protocol_err sets (sticky until reset) on any of:
  - pmem_read and pmem_write both high in IDLE at acceptance;
  - during BUSY, pmem_address, pmem_read, pmem_write or (for writes) pmem_wdata differs from the latched value;
  - requester drops its request before pmem_resp.
  The access still completes normally; detection never alters data or timing.
- Undefined: protocol_err is tied to 0 and no checking logic is built.

Test Plan:
- Reset mid-read: with READ_LATENCY=4, accept a read, assert reset on cycle 2 of BUSY -> pmem_resp stays 0, pmem_rdata=0, next request is accepted normally.
- Write then read: write 0xA5A5...A5 to address 0x0040, then read 0x0040 -> pmem_resp 5 cycles after each acceptance (LATENCY=4), rdata=0xA5A5...A5; a read of 0x005F also returns it (same block).
- Aliasing: DEPTH_LOG2=4, write block X to 0x0020 and read 0x0220 -> rdata=X.
- Simultaneous read+write at 0x0100 with data 0x1234... -> treated as a write, array updated, pmem_rdata unchanged; with PMEM_PROTOCOL_CHECK_EN, protocol_err=1 and stays 1 until reset.
- Held request after resp: keep pmem_read high for 2 cycles past resp -> a second access is accepted in the IDLE cycle and a second resp pulse arrives LATENCY+1 cycles later; no double pulse.
- LATENCY=1 boundary: read accepted at edge k -> pmem_resp high in the cycle after edge k+1, exactly one cycle wide.
